// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, redirect squash, data-memory waits with timeout.
// Optional PIPE_CTRL_PERF_EN adds 32-bit counters for load-use bubbles, redirects and memory-stall cycles.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic       if_id_uses_rs2,
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rd,
    input  logic       ex_redirect,
    input  logic       dmem_req,
    input  logic       dmem_ack,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_timeout,
    output logic [1:0] state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_redir_cnt,
    output logic [31:0] perf_mem_cnt
`endif
);

    // state      | meaning
    // S_RUN      | normal issue; hazards resolved combinationally
    // S_MEM_WAIT | data access outstanding, whole pipe frozen, timer counting
    // S_ERROR    | memory never answered; pipe squashed until reset
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERROR    = 2'd2;

    localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;

    logic lu;
    logic mh;
    logic issue;
    logic hold;
    logic err;
    logic redir_fire;
    logic lu_fire;
    logic [7:0] timer_inc;

    assign lu = id_ex_memread && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
    assign mh = dmem_req && !dmem_ack;
    assign timer_inc = timer_q + 8'd1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        issue   = 1'b0;
        hold    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mh) begin
                    hold    = 1'b1;
                    state_d = S_MEM_WAIT;
                    timer_d = 8'd0;
                end else begin
                    issue = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!dmem_ack) begin
                    hold    = 1'b1;
                    timer_d = timer_inc;
                    if (timer_inc == TIMER_LAST) begin
                        state_d = S_ERROR;
                    end
                end else begin
                    issue   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_ERROR: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                timer_d = 8'd0;
            end
        endcase
    end

    // A redirect squashes the dependent instruction anyway, so it suppresses the load-use bubble.
    assign redir_fire = issue && ex_redirect;
    assign lu_fire    = issue && !ex_redirect && lu;

    always_comb begin
        pc_en       = issue && !lu_fire;
        if_id_en    = issue && !lu_fire;
        id_ex_en    = issue;
        ex_mem_en   = issue;
        mem_wb_en   = issue;
        if_id_flush = redir_fire || err;
        id_ex_flush = redir_fire || lu_fire || err;
        mem_timeout = err;
        state_o     = state_q;
        if (!rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            mem_timeout = 1'b0;
            state_o     = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_lu_q, perf_redir_q, perf_mem_q;

    // Counters naturally freeze in ERROR since no issue or hold happens there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_lu_q    <= 32'd0;
            perf_redir_q <= 32'd0;
            perf_mem_q   <= 32'd0;
        end else if (state_q != S_ERROR) begin
            perf_lu_q    <= perf_lu_q + {31'd0, lu_fire};
            perf_redir_q <= perf_redir_q + {31'd0, redir_fire};
            perf_mem_q   <= perf_mem_q + {31'd0, hold};
        end
    end

    assign perf_lu_cnt    = perf_lu_q;
    assign perf_redir_cnt = perf_redir_q;
    assign perf_mem_cnt   = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed cases with literal expectations plus randomized traffic
// checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic       if_id_uses_rs2, id_ex_memread, ex_redirect, dmem_req, dmem_ack;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_timeout;
    logic [1:0] state_o;

    pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: error latched, waiting flag, consecutive unanswered memory cycles.
    bit m_err = 0;
    bit m_wait = 0;
    int m_unacked = 0;

    wire [9:0] dut_bus = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                          if_id_flush, id_ex_flush, mem_timeout, state_o};

    function automatic bit model_held();
        if (m_wait) return !dmem_ack;
        return dmem_req && !dmem_ack;
    endfunction

    function automatic logic [9:0] model_out();
        bit l;
        logic [1:0] st;
        l = id_ex_memread && (id_ex_rd != 0) &&
            ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
        st = m_wait ? 2'd1 : 2'd0;
        if (!rst)         return {5'b00000, 2'b11, 1'b0, 2'd0};
        if (m_err)        return {5'b00000, 2'b11, 1'b1, 2'd2};
        if (model_held()) return {5'b00000, 2'b00, 1'b0, st};
        if (ex_redirect)  return {5'b11111, 2'b11, 1'b0, st};
        if (l)            return {5'b00111, 2'b01, 1'b0, st};
        return {5'b11111, 2'b00, 1'b0, st};
    endfunction

    task automatic model_tick();
        if (!rst) begin
            m_err = 0; m_wait = 0; m_unacked = 0;
        end else if (!m_err) begin
            if (model_held()) begin
                m_unacked++;
                m_wait = 1;
                if (m_unacked >= TO) m_err = 1;
            end else begin
                m_wait = 0;
                m_unacked = 0;
            end
        end
    endtask

    task automatic cyc(input string name, input bit use_lit, input logic [9:0] lit);
        logic [9:0] exp_v, got;
        @(negedge clk);
        exp_v = model_out();
        got = dut_bus;
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s model: got %b expected %b at %0t", name, got, exp_v, $time);
        end
        if (use_lit) begin
            vectors++;
            if (got !== lit) begin
                miscompares++;
                $display("FAIL %s literal: got %b expected %b at %0t", name, got, lit, $time);
            end
        end
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                          input logic mr, input logic [4:0] rd, input logic redir,
                          input logic req, input logic ack);
        if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_uses_rs2 = u2;
        id_ex_memread = mr; id_ex_rd = rd; ex_redirect = redir;
        dmem_req = req; dmem_ack = ack;
    endtask

    localparam logic [9:0] L_RST   = 10'b00000_11_0_00;
    localparam logic [9:0] L_RUN   = 10'b11111_00_0_00;
    localparam logic [9:0] L_LU    = 10'b00111_01_0_00;
    localparam logic [9:0] L_REDIR = 10'b11111_11_0_00;
    localparam logic [9:0] L_HOLD0 = 10'b00000_00_0_00;
    localparam logic [9:0] L_HOLD1 = 10'b00000_00_0_01;
    localparam logic [9:0] L_ERR   = 10'b00000_11_1_10;

    initial begin
        int streak;
        int err_cycles;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset_out", 1, L_RST);
        rst = 1'b1;
        cyc("run_idle", 1, L_RUN);

        // load x5 then add x6,x5,x7
        set_in(5, 7, 1, 1, 5, 0, 0, 0);
        cyc("lu_bubble", 1, L_LU);
        set_in(6, 0, 0, 0, 6, 0, 0, 0);
        cyc("lu_release", 1, L_RUN);
        set_in(0, 0, 0, 1, 0, 0, 0, 0);
        cyc("lu_rd0", 1, L_RUN);
        set_in(1, 6, 0, 1, 6, 0, 0, 0);
        cyc("lu_rs2_unused", 1, L_RUN);
        set_in(1, 6, 1, 1, 6, 0, 0, 0);
        cyc("lu_rs2_used", 1, L_LU);
        set_in(5, 0, 0, 1, 5, 1, 0, 0);
        cyc("redir_over_lu", 1, L_REDIR);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("ack_no_req", 1, L_RUN);
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        cyc("ack_first", 1, L_RUN);

        // memory wait of 3 cycles with a redirect pending throughout
        set_in(0, 0, 0, 0, 0, 1, 1, 0);
        cyc("wait_run", 1, L_HOLD0);
        cyc("wait_1", 1, L_HOLD1);
        cyc("wait_2", 1, L_HOLD1);
        dmem_ack = 1'b1;
        cyc("wait_ack_redir", 1, 10'b11111_11_0_01);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("wait_back_run", 1, L_RUN);

        // timeout: 4 unanswered cycles then ERROR
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cyc("to_run", 1, L_HOLD0);
        cyc("to_w1", 1, L_HOLD1);
        cyc("to_w2", 1, L_HOLD1);
        cyc("to_w3", 1, L_HOLD1);
        cyc("to_err", 1, L_ERR);
        dmem_ack = 1'b1;
        cyc("to_err_sticky", 1, L_ERR);
        rst = 1'b0;
        cyc("to_reset", 1, L_RST);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("to_after_reset", 1, L_RUN);

        // reset in the middle of a memory wait
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cyc("mr_run", 1, L_HOLD0);
        cyc("mr_w1", 1, L_HOLD1);
        rst = 1'b0;
        cyc("mr_reset", 1, L_RST);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("mr_after", 1, L_RUN);
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cyc("mr_timer_run", 1, L_HOLD0);
        cyc("mr_timer_w1", 1, L_HOLD1);
        cyc("mr_timer_w2", 1, L_HOLD1);
        dmem_ack = 1'b1;
        cyc("mr_timer_ack", 1, 10'b11111_00_0_01);

        // randomized traffic
        streak = 0;
        err_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 3),
                   1'($urandom_range(0, 1)));
            if (streak == 0 && $urandom_range(0, 99) < 5) streak = 6;
            if (streak > 0) begin
                dmem_req = 1'b1;
                dmem_ack = 1'b0;
                streak--;
            end
            err_cycles = m_err ? err_cycles + 1 : 0;
            rst = !(($urandom_range(0, 99) < 2) || (err_cycles > 3));
            cyc("random", 0, 10'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipelined core. Consumes hazard conditions from ID/EX (load-use), EX (taken branch/jal/jalr redirect) and MEM (data-memory wait handshake), and drives the enable and flush controls of the PC and every pipeline register. A small FSM tracks multi-cycle memory waits and enforces a timeout that locks the pipeline into an error state.

## Interface
- `MEM_TIMEOUT`, 16: maximum number of consecutive MEM_WAIT cycles before error; legal range 2..255.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low
- `if_id_rs1`  in  5  rs1 field of the instruction in IF/ID
- `if_id_rs2`  in  5  rs2 field of the instruction in IF/ID
- `if_id_uses_rs2`  in  1  IF/ID instruction reads rs2 (R/S/B types)
- `id_ex_memread`  in  1  instruction in ID/EX is a load
- `id_ex_rd`  in  5  destination register of ID/EX instruction
- `ex_redirect`  in  1  EX resolved a taken branch, jal or jalr
- `dmem_req`  in  1  MEM stage is issuing a data-memory access
- `dmem_ack`  in  1  data memory completes the access this cycle
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register load enables
- `if_id_flush`, `id_ex_flush`  out  1 each  load a NOP bubble instead of stage data
- `mem_timeout`  out  1  sticky error flag
- `state_o`  out  2  current FSM state (RUN=0, MEM_WAIT=1, ERROR=2)

## Operation
- Outputs are combinational from state and inputs (Mealy); state, timer and counters are registered.
- Load-use hazard `lu` = id_ex_memread && id_ex_rd != 0 && (id_ex_rd == if_id_rs1 || (if_id_uses_rs2 && id_ex_rd == if_id_rs2)).
- Memory hold `mh` = dmem_req && !dmem_ack.
- RUN, priority highest first:
  - mh: all five enables 0, flushes 0; next MEM_WAIT, timer cleared to 0.
  - ex_redirect: all enables 1, if_id_flush=1, id_ex_flush=1 (redirect overrides a coincident lu); stay RUN.
  - lu: pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1; stay RUN.
  - none: all enables 1, flushes 0.
- MEM_WAIT:
  - dmem_ack=0: all enables 0, flushes 0; timer increments; if timer == MEM_TIMEOUT-1, next ERROR.
  - dmem_ack=1: outputs evaluated exactly as RUN with mh=0 (redirect/lu still honoured); next RUN.
- ERROR: all enables 0, if_id_flush=1, id_ex_flush=1, mem_timeout=1; exits only by reset.
- Redirect or load-use present while held is not lost: EX/ID registers are frozen, so condition re-evaluates on release.
- Reset (rst=0 at a clock edge): state RUN, timer 0, mem_timeout 0, perf counters 0. While rst=0, outputs forced: all enables 0, both flushes 1, mem_timeout 0, state_o 0.

## Timing
- Zero-cycle latency from any hazard input to outputs; hazard inputs must settle within the cycle.
- Load-use bubble: exactly 1 cycle per occurrence (ID/EX rd advances, lu deasserts next cycle).
- Redirect penalty: 2 squashed instructions, 1 controller cycle.
- Memory access with ack on first cycle: no stall. Ack after N wait cycles: N stall cycles.
- Timeout: ERROR entered on the edge ending the MEM_TIMEOUT-th unacked wait cycle (RUN cycle plus MEM_TIMEOUT-1 MEM_WAIT cycles); mem_timeout visible next cycle.
- dmem_ack without dmem_req in RUN is ignored.

## Configuration
- `PIPE_CTRL_PERF_EN`: defined → adds outputs `perf_lu_cnt`, `perf_redir_cnt`, `perf_mem_cnt` (32 bits each, wrap at 2^32) counting load-use bubbles, redirects and memory-stall cycles; cleared by reset, frozen in ERROR. Undefined → ports and counters absent, no other behaviour change.

## Test plan
- Load x5 in ID/EX, IF/ID `add x6,x5,x7` (rs1=5) -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1.
- id_ex_rd=0 with memread and rs1=0 -> no stall; rd=rs2 match with if_id_uses_rs2=0 -> no stall.
- ex_redirect=1 and lu=1 same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; no load-use bubble.
- dmem_req=1, ack after 3 cycles with ex_redirect=1 throughout -> 3 cycles all enables 0; ack cycle shows both flushes 1; state_o returns 0.
- MEM_TIMEOUT=4, dmem_req=1, ack never -> ERROR after 4 stalled cycles, mem_timeout=1 sticky; rst=0 for one edge -> state_o=0, mem_timeout=0.
- Reset asserted mid MEM_WAIT -> next cycle RUN, timer 0, enables 1 if no hazards.
